// File: rtl/rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: a frame becomes readable only once its last byte lands with a good FCS.
// Bad or overflowing frames are rolled back so that no byte of them is ever emitted.
module rx_frame_fifo #(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [7:0]           S_AXIS_TDATA,
    input  logic                 S_AXIS_TVALID,
    input  logic                 S_AXIS_TLAST,
    input  logic                 S_AXIS_TUSER,
    output logic [7:0]           M_AXIS_TDATA,
    output logic                 M_AXIS_TVALID,
    output logic                 M_AXIS_TLAST,
    output logic                 M_AXIS_TUSER,
    input  logic                 M_AXIS_TREADY,
    output logic [CNT_WIDTH-1:0] DROP_COUNT,
    output logic                 DROP_PULSE
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} wrState_t;

    logic [8:0]            r_mem [DEPTH];
    logic [8:0]            r_ramQ;
    logic [ADDR_WIDTH:0]   r_wrCommit, r_wrSpec, r_rd;
    wrState_t              r_state, w_stateNxt;
    logic                  w_full, w_ramWe, w_dropEvt;
    logic [ADDR_WIDTH:0]   w_wrSpecNxt, w_wrCommitNxt;
    logic                  r_ramVld, w_rdEn, w_pop;
    logic [1:0]            w_occ;
    logic                  r_outVld, r_outLast, r_skVld, r_skLast;
    logic [7:0]            r_outData, r_skData;
    logic                  r_dropPulse;
    logic [CNT_WIDTH-1:0]  r_dropCnt;

    // Full is judged against the registered read pointer only.
    assign w_full = (r_wrSpec - r_rd) == FULL_LEVEL;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_stateNxt;
    end

    always_comb begin
        w_stateNxt = r_state;
        if (S_AXIS_TVALID) begin
            case (r_state)
                ST_IDLE, ST_RECV: begin
                    if (S_AXIS_TLAST)  w_stateNxt = ST_IDLE;
                    else if (w_full)   w_stateNxt = ST_DROP;
                    else               w_stateNxt = ST_RECV;
                end
                ST_DROP:  if (S_AXIS_TLAST) w_stateNxt = ST_IDLE;
                default:  w_stateNxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ramWe       = 1'b0;
        w_dropEvt     = 1'b0;
        w_wrSpecNxt   = r_wrSpec;
        w_wrCommitNxt = r_wrCommit;
        if (S_AXIS_TVALID) begin
            case (r_state)
                ST_IDLE, ST_RECV: begin
                    if (w_full) begin
                        w_wrSpecNxt = r_wrCommit;
                        w_dropEvt   = S_AXIS_TLAST;
                    end else begin
                        w_ramWe = 1'b1;
                        if (S_AXIS_TLAST && S_AXIS_TUSER) begin
                            w_wrSpecNxt = r_wrCommit;
                            w_dropEvt   = 1'b1;
                        end else if (S_AXIS_TLAST) begin
                            w_wrSpecNxt   = r_wrSpec + 1'b1;
                            w_wrCommitNxt = r_wrSpec + 1'b1;
                        end else begin
                            w_wrSpecNxt = r_wrSpec + 1'b1;
                        end
                    end
                end
                ST_DROP:  w_dropEvt = S_AXIS_TLAST;
                default:  w_dropEvt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wrSpec    <= '0;
            r_wrCommit  <= '0;
            r_dropPulse <= 1'b0;
            r_dropCnt   <= '0;
        end else begin
            r_wrSpec    <= w_wrSpecNxt;
            r_wrCommit  <= w_wrCommitNxt;
            r_dropPulse <= w_dropEvt;
            if (w_dropEvt && (r_dropCnt != '1))
                r_dropCnt <= r_dropCnt + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_ramWe)
            r_mem[r_wrSpec[ADDR_WIDTH-1:0]] <= {S_AXIS_TLAST, S_AXIS_TDATA};
        if (w_rdEn)
            r_ramQ <= r_mem[r_rd[ADDR_WIDTH-1:0]];
    end

    // A read is launched only if its result is guaranteed a slot in the output register or skid.
    assign w_pop  = r_outVld & M_AXIS_TREADY;
    assign w_occ  = {1'b0, r_outVld} + {1'b0, r_skVld} + {1'b0, r_ramVld};
    assign w_rdEn = (r_rd != r_wrCommit) && ((w_occ - {1'b0, w_pop}) <= 2'd1);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd      <= '0;
            r_ramVld  <= 1'b0;
            r_outVld  <= 1'b0;
            r_outLast <= 1'b0;
            r_outData <= '0;
            r_skVld   <= 1'b0;
            r_skLast  <= 1'b0;
            r_skData  <= '0;
        end else begin
            r_ramVld <= w_rdEn;
            if (w_rdEn)
                r_rd <= r_rd + 1'b1;
            if (w_pop || !r_outVld) begin
                if (r_skVld) begin
                    r_outVld  <= 1'b1;
                    r_outLast <= r_skLast;
                    r_outData <= r_skData;
                    r_skVld   <= r_ramVld;
                    r_skLast  <= r_ramQ[8];
                    r_skData  <= r_ramQ[7:0];
                end else begin
                    r_outVld <= r_ramVld;
                    if (r_ramVld) begin
                        r_outLast <= r_ramQ[8];
                        r_outData <= r_ramQ[7:0];
                    end
                end
            end else if (r_ramVld) begin
                r_skVld  <= 1'b1;
                r_skLast <= r_ramQ[8];
                r_skData <= r_ramQ[7:0];
            end
        end
    end

    assign M_AXIS_TDATA  = r_outData;
    assign M_AXIS_TVALID = r_outVld;
    assign M_AXIS_TLAST  = r_outLast;
    assign M_AXIS_TUSER  = 1'b0;
    assign DROP_COUNT    = r_dropCnt;
    assign DROP_PULSE    = r_dropPulse;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Self-checking bench for rx_frame_fifo: a full-size instance and a small one (64-byte buffer, 2-bit counter)
// share the same stimulus; each test selects which instance's outputs are observed.
module tb_rx_frame_fifo;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  sTdata;
    logic        sTvalid, sTlast, sTuser, mTready;
    logic        sel;
    int          readyMode;

    logic [7:0]  bigTdata, smlTdata;
    logic        bigTvalid, bigTlast, bigTuser, smlTvalid, smlTlast, smlTuser;
    logic [15:0] bigDropCount;
    logic [1:0]  smlDropCount;
    logic        bigDropPulse, smlDropPulse;

    logic [7:0]  mTdata;
    logic        mTvalid, mTlast, mTuser, mDropPulse;
    logic [15:0] mDropCount;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  gotQ[$];
    logic [8:0]  expQ[$];
    int          pulseCnt = 0;
    int          stallViol = 0;
    logic        prevStall = 1'b0;
    logic [7:0]  prevData = '0;
    logic        prevLast = 1'b0;

    typedef struct {
        int          len;
        logic [7:0]  start;
        logic        bad;
        int          readyMode;
        logic        gapAfter;
        logic        expPass;
        logic [15:0] expDrop;
    } vec_t;

    vec_t vecs[5];
    int   expSat[5];

    always #5 aclk = ~aclk;

    rx_frame_fifo dutBig (
        .ACLK(aclk), .ARESET(areset),
        .S_AXIS_TDATA(sTdata), .S_AXIS_TVALID(sTvalid), .S_AXIS_TLAST(sTlast), .S_AXIS_TUSER(sTuser),
        .M_AXIS_TDATA(bigTdata), .M_AXIS_TVALID(bigTvalid), .M_AXIS_TLAST(bigTlast), .M_AXIS_TUSER(bigTuser),
        .M_AXIS_TREADY(mTready), .DROP_COUNT(bigDropCount), .DROP_PULSE(bigDropPulse)
    );

    rx_frame_fifo #(.ADDR_WIDTH(6), .CNT_WIDTH(2)) dutSmall (
        .ACLK(aclk), .ARESET(areset),
        .S_AXIS_TDATA(sTdata), .S_AXIS_TVALID(sTvalid), .S_AXIS_TLAST(sTlast), .S_AXIS_TUSER(sTuser),
        .M_AXIS_TDATA(smlTdata), .M_AXIS_TVALID(smlTvalid), .M_AXIS_TLAST(smlTlast), .M_AXIS_TUSER(smlTuser),
        .M_AXIS_TREADY(mTready), .DROP_COUNT(smlDropCount), .DROP_PULSE(smlDropPulse)
    );

    assign mTdata     = sel ? smlTdata     : bigTdata;
    assign mTvalid    = sel ? smlTvalid    : bigTvalid;
    assign mTlast     = sel ? smlTlast     : bigTlast;
    assign mTuser     = sel ? smlTuser     : bigTuser;
    assign mDropPulse = sel ? smlDropPulse : bigDropPulse;
    assign mDropCount = sel ? {14'd0, smlDropCount} : bigDropCount;

    // Ready changes just after the edge; everything is observed on the falling edge.
    always @(posedge aclk) begin
        #1;
        case (readyMode)
            0:       mTready = 1'b0;
            1:       mTready = 1'b1;
            default: mTready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge aclk) begin
        if (areset) begin
            gotQ.delete();
            pulseCnt  = 0;
            prevStall = 1'b0;
        end else begin
            if (prevStall && (!mTvalid || mTdata != prevData || mTlast != prevLast))
                stallViol++;
            if (mTvalid && mTready)
                gotQ.push_back({mTlast, mTdata});
            if (mDropPulse)
                pulseCnt++;
            prevStall = mTvalid && !mTready;
            prevData  = mTdata;
            prevLast  = mTlast;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendFrame(input int len, input logic [7:0] start, input logic bad);
        for (int i = 0; i < len; i++) begin
            @(posedge aclk); #1;
            sTvalid = 1'b1;
            sTdata  = 8'(start + i);
            sTlast  = (i == len - 1);
            sTuser  = bad && (i == len - 1);
        end
    endtask

    task automatic endFrame();
        @(posedge aclk); #1;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        sTuser  = 1'b0;
    endtask

    task automatic expectFrame(input int len, input logic [7:0] start);
        for (int i = 0; i < len; i++)
            expQ.push_back({(i == len - 1), 8'(start + i)});
    endtask

    task automatic assertReset();
        @(posedge aclk); #1;
        areset  = 1'b1;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        sTuser  = 1'b0;
        sTdata  = '0;
        expQ.delete();
        @(negedge aclk);
        checkOutput("reset tvalid", 32'(mTvalid), 0);
        checkOutput("reset tdata", 32'(mTdata), 0);
        checkOutput("reset tlast", 32'(mTlast), 0);
        checkOutput("reset dropcount", 32'(mDropCount), 0);
        checkOutput("reset droppulse", 32'(mDropPulse), 0);
    endtask

    task automatic resetDut(input logic which);
        sel = which;
        assertReset();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        readyMode = v.readyMode;
        if (v.expPass)
            expectFrame(v.len, v.start);
        sendFrame(v.len, v.start, v.bad);
        if (v.gapAfter) begin
            endFrame();
            repeat (3) @(posedge aclk);
            @(negedge aclk);
            checkOutput($sformatf("vec%0d dropcount", idx), 32'(mDropCount), 32'(v.expDrop));
        end
    endtask

    task automatic drainAndCompare(input string name);
        int w = 0;
        while (gotQ.size() < expQ.size() && w < 3000) begin
            @(negedge aclk);
            w++;
        end
        repeat (10) @(negedge aclk);
        checkOutput({name, " count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("%s byte%0d", name, i), 32'(gotQ[i]), 32'(expQ[i]));
        checkOutput({name, " stable"}, 32'(stallViol), 0);
    endtask

    initial begin
        vecs[0] = '{60, 8'h80, 1'b1, 1, 1'b1, 1'b0, 16'd1};
        vecs[1] = '{42, 8'h10, 1'b0, 1, 1'b1, 1'b1, 16'd1};
        vecs[2] = '{10, 8'hA0, 1'b0, 2, 1'b0, 1'b1, 16'd1};
        vecs[3] = '{1,  8'h55, 1'b0, 2, 1'b0, 1'b1, 16'd1};
        vecs[4] = '{63, 8'h20, 1'b0, 2, 1'b1, 1'b1, 16'd1};
        expSat  = '{1, 2, 3, 3, 3};

        areset = 1'b1; sTvalid = 1'b0; sTlast = 1'b0; sTuser = 1'b0; sTdata = '0;
        mTready = 1'b0; readyMode = 1; sel = 1'b0;

        $display("[TB] test 1: 64-byte good frame and output latency");
        resetDut(1'b0);
        readyMode = 1;
        expectFrame(64, 8'h00);
        sendFrame(64, 8'h00, 1'b0);
        @(posedge aclk); #1 sTvalid = 1'b0; sTlast = 1'b0;
        @(negedge aclk);
        checkOutput("lat after N", 32'(mTvalid), 0);
        @(posedge aclk); @(negedge aclk);
        checkOutput("lat after N+1", 32'(mTvalid), 0);
        @(posedge aclk); @(negedge aclk);
        checkOutput("lat after N+2", 32'(mTvalid), 1);
        checkOutput("lat first byte", 32'(mTdata), 32'h00);
        checkOutput("tuser zero", 32'(mTuser), 0);
        drainAndCompare("t1");
        checkOutput("t1 dropcount", 32'(mDropCount), 0);

        $display("[TB] tests 2/4: table of bad, good and back-to-back frames");
        resetDut(1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(vecs[i], i);
        drainAndCompare("tbl");
        checkOutput("tbl pulses", 32'(pulseCnt), 1);

        $display("[TB] test 3: overflow drop on small buffer");
        resetDut(1'b1);
        readyMode = 0;
        sendFrame(70, 8'h00, 1'b0);
        endFrame();
        repeat (4) @(negedge aclk);
        checkOutput("t3 dropcount", 32'(mDropCount), 1);
        checkOutput("t3 pulses", 32'(pulseCnt), 1);
        checkOutput("t3 tvalid", 32'(mTvalid), 0);
        expectFrame(20, 8'h30);
        sendFrame(20, 8'h30, 1'b0);
        endFrame();
        repeat (5) @(negedge aclk);
        checkOutput("t3 stalled tvalid", 32'(mTvalid), 1);
        checkOutput("t3 stalled tdata", 32'(mTdata), 32'h30);
        checkOutput("t3 nothing taken", 32'(gotQ.size()), 0);
        readyMode = 1;
        drainAndCompare("t3");

        $display("[TB] test 5: reset mid-frame and mid-read");
        resetDut(1'b0);
        readyMode = 1;
        sendFrame(5, 8'hE0, 1'b1);
        endFrame();
        repeat (3) @(negedge aclk);
        checkOutput("t5 pre dropcount", 32'(mDropCount), 1);
        readyMode = 0;
        sendFrame(30, 8'h41, 1'b0);
        endFrame();
        repeat (4) @(negedge aclk);
        checkOutput("t5 held tvalid", 32'(mTvalid), 1);
        checkOutput("t5 held tdata", 32'(mTdata), 32'h41);
        sendFrame(20, 8'h90, 1'b0);
        assertReset();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        readyMode = 1;
        expectFrame(30, 8'h70);
        sendFrame(30, 8'h70, 1'b0);
        endFrame();
        drainAndCompare("t5");
        checkOutput("t5 dropcount", 32'(mDropCount), 0);

        $display("[TB] test 6: drop counter saturation");
        resetDut(1'b1);
        readyMode = 1;
        for (int k = 0; k < 5; k++) begin
            sendFrame(3, 8'(16 * (k + 1)), 1'b1);
            endFrame();
            repeat (2) @(negedge aclk);
            checkOutput($sformatf("t6 count%0d", k), 32'(mDropCount), 32'(expSat[k]));
        end
        checkOutput("t6 pulses", 32'(pulseCnt), 5);
        checkOutput("t6 no output", 32'(gotQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
